// File: rtl/rr_mux_sched.sv
// rr_mux_sched: round-robin scheduler for a 4:1 x WIDTH mux.
// Drives the mux select, captures the mux output and presents it on a
// registered valid/ready stream together with its channel index.
// Optional feature: define RR_MUX_STATS_EN to add gnt_cnt, four
// saturating 8-bit per-channel grant counters.
module rr_mux_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [1:0]       sel,
  input  logic [WIDTH-1:0] mux_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_ch
`ifdef RR_MUX_STATS_EN
  ,
  output logic [31:0]      gnt_cnt
`endif
);

  logic [1:0] ptr;
  logic [1:0] gnt;
  logic       any;
  logic       load;

  assign any  = |in_valid;
  // The output register can take a new word when it is empty or being drained.
  assign load = !out_valid || out_ready;
  // With no requester gnt stays at ptr, so sel == gnt covers both cases.
  assign sel  = gnt;

  // Scan from ptr upward with 2-bit wrap; the nearest requester wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    gnt = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (in_valid[ptr + 2'(k)]) gnt = ptr + 2'(k);
    end
  end

  // One-hot accept towards the granted producer when the output can load.
  always_comb begin
    in_ready = '0;
    if (load && any) in_ready[gnt] = 1'b1;
  end

  // Output register and priority pointer; the pointer moves past each grant.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= mux_y;
        out_ch    <= gnt;
        ptr       <= gnt + 2'd1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RR_MUX_STATS_EN
  logic [7:0] cnt [4];

  // Per-channel grant counters, saturating at 255.
  always_ff @(posedge clk) begin
    // NOTE: this small counter array is explicit state, so it is cleared on reset like any register.
    for (int i = 0; i < 4; i++) begin
      if (rst)                           cnt[i] <= '0;
      else if (in_ready[i] && cnt[i] != 8'hFF) cnt[i] <= cnt[i] + 8'd1;
    end
  end

  assign gnt_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_rr_mux_sched.sv
// Testbench for rr_mux_sched: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_rr_mux_sched;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       in_valid = '0;
  logic [3:0]       in_ready;
  logic [1:0]       sel;
  logic [WIDTH-1:0] mux_y;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_ch;
  logic [WIDTH-1:0] w [4];
`ifdef RR_MUX_STATS_EN
  logic [31:0]      gnt_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  rr_mux_sched #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mux_y     (mux_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
`ifdef RR_MUX_STATS_EN
    ,
    .gnt_cnt   (gnt_cnt)
`endif
  );

  always #5 clk = ~clk;

  // The external 4:1 mux.
  assign mux_y = w[sel];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int               m_ptr = 0;
  bit               m_ov  = 1'b0;
  logic [WIDTH-1:0] m_od  = '0;
  int               m_oc  = 0;
  int               m_cnt [4] = '{0, 0, 0, 0};
  logic [3:0]       m_last_ready = '0;

  function automatic int find_grant(input logic [3:0] req, input int p);
    for (int k = 0; k < 4; k++) if (req[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic int m_grant();
    return find_grant(in_valid, m_ptr);
  endfunction

  function automatic bit m_take();
    return (m_grant() >= 0) && (!m_ov || out_ready);
  endfunction

  function automatic int m_sel();
    return (m_grant() >= 0) ? m_grant() : m_ptr;
  endfunction

  function automatic logic [3:0] m_ready();
    return m_take() ? 4'(1 << m_grant()) : 4'b0000;
  endfunction

  function automatic logic [31:0] m_cnt_word();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(m_cnt[i]);
    return r;
  endfunction

  // Model state advance at each clock edge.
  always @(posedge clk) begin
    m_last_ready <= m_ready();
    if (rst) begin
      m_ptr <= 0;
      m_ov  <= 1'b0;
      m_od  <= '0;
      m_oc  <= 0;
      for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
    end else if (m_take()) begin
      m_ov  <= 1'b1;
      m_od  <= w[m_grant()];
      m_oc  <= m_grant();
      m_ptr <= (m_grant() + 1) % 4;
      if (m_cnt[m_grant()] < 255) m_cnt[m_grant()] <= m_cnt[m_grant()] + 1;
    end else if (!m_ov || out_ready) begin
      m_ov <= 1'b0;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_sel",       32'(sel),       32'(m_sel()));
      check("m_in_ready",  32'(in_ready),  32'(m_ready()));
      check("m_out_valid", 32'(out_valid), 32'(m_ov));
      check("m_out_data",  32'(out_data),  32'(m_od));
      check("m_out_ch",    32'(out_ch),    32'(m_oc));
`ifdef RR_MUX_STATS_EN
      check("m_gnt_cnt",   gnt_cnt,        m_cnt_word());
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    w[0] = 4'b0001; w[1] = 4'b0010; w[2] = 4'b0100; w[3] = 4'b1000;
    rst = 1'b1; out_ready = 1'b1; in_valid = '0;
    cyc(); cyc();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    look();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_out_ch",    32'(out_ch),    0);
    check("rst_in_ready",  32'(in_ready),  0);
    check("rst_sel",       32'(sel),       0);
    cyc();

    // All channels requesting: strict rotation 0,1,2,3,0,1,2,3
    in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      look();
      check("rr_sel", 32'(sel), k % 4);
      if (k > 0) begin
        check("rr_out_ch",   32'(out_ch),   (k - 1) % 4);
        check("rr_out_data", 32'(out_data), 1 << ((k - 1) % 4));
      end
      cyc();
    end

    // Single requester on channel 2, granted back-to-back
    in_valid = 4'b0100;
    for (int j = 0; j < 3; j++) begin
      look();
      check("single_in_ready", 32'(in_ready), 32'h4);
      check("single_sel",      32'(sel),      2);
      check("single_out_ch",   32'(out_ch),   (j == 0) ? 3 : 2);
      cyc();
    end

    // Back-pressure: output frozen, no accept, sel shows pending choice
    in_valid = 4'b1010; out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      look();
      check("bp_in_ready",  32'(in_ready),  0);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_out_ch",    32'(out_ch),    2);
      check("bp_out_data",  32'(out_data),  32'h4);
      check("bp_sel",       32'(sel),       3);
      cyc();
    end
    out_ready = 1'b1;
    look();
    check("drain_in_ready", 32'(in_ready), 32'h8);
    cyc();
    look();
    check("drain_out_ch",    32'(out_ch),    3);
    check("drain_out_data",  32'(out_data),  32'h8);
    check("drain_out_valid", 32'(out_valid), 1);

    // ptr=3 after a channel-2 grant; channels 0,1 then alternate from 0
    in_valid = 4'b0100;
    cyc();
    in_valid = 4'b0011;
    for (int j = 0; j < 3; j++) begin
      look();
      check("wrap_sel", 32'(sel), (j == 1) ? 1 : 0);
      cyc();
    end

    // Reset while holding a word under back-pressure
    out_ready = 1'b0;
    look();
    check("hold_out_valid", 32'(out_valid), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; in_valid = '0;
    look();
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_data",  32'(out_data),  0);
    check("mid_rst_out_ch",    32'(out_ch),    0);
    check("mid_rst_in_ready",  32'(in_ready),  0);
    in_valid = 4'b1010; out_ready = 1'b1;
    #1;
    check("post_rst_sel",      32'(sel),      1);
    check("post_rst_in_ready", 32'(in_ready), 32'h2);
    cyc();
    look();
    check("post_rst_out_ch",   32'(out_ch),   1);
    check("post_rst_out_data", 32'(out_data), 32'h2);

`ifdef RR_MUX_STATS_EN
    // Counter saturation and clear
    rst = 1'b1;
    cyc();
    rst = 1'b0; in_valid = 4'b0001; out_ready = 1'b1;
    repeat (300) cyc();
    look();
    check("cnt_saturated", gnt_cnt, 32'h0000_00FF);
    rst = 1'b1;
    cyc();
    rst = 1'b0; in_valid = '0;
    look();
    check("cnt_cleared", gnt_cnt, 32'h0);
`endif

    // Randomized traffic; producers hold word and valid until accepted
    cyc();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!(in_valid[i] && !m_last_ready[i])) begin
          in_valid[i] = ($urandom_range(0, 99) < 55);
          w[i]        = WIDTH'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 249) == 0);
      cyc();
    end
    rst = 1'b0;
    look();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
